// File: rtl/tv_sequencer.sv
// tv_sequencer: exhaustive test-vector sequencer for a combinational DUT; optional TVSEQ_STOP_ON_FAIL_EN ends the run at the first mismatch
module tv_sequencer #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  exp_addr,
    input  logic [N_OUT-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  fail_vec,
    output logic             fail_valid
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};
    localparam logic [SW-1:0] SET_END = SW'(SETTLE - 1);
    state_t state, next;
    logic [N_IN:0] vec;
    logic [SW-1:0] cnt;
    logic mismatch, go, stop;
    assign mismatch = dut_out != exp_data;
    assign go = start && (state == IDLE || state == DONE);
`ifdef TVSEQ_STOP_ON_FAIL_EN
    assign stop = (vec == LAST) || mismatch;
`else
    assign stop = vec == LAST;
`endif
    assign dut_in = vec[N_IN-1:0];
    assign exp_addr = dut_in;
    assign busy = state == APPLY || state == SAMPLE;
    assign done = state == DONE;
    assign pass = done && err_cnt == '0;
    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : next;
    // next-state decode: hold each vector SETTLE cycles, then one sample cycle
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? APPLY : state;
            APPLY:      next = (cnt == SET_END) ? SAMPLE : APPLY;
            SAMPLE:     next = stop ? DONE : APPLY;
            default:    next = IDLE;
        endcase
    end
    // vector walk, settle timer, error count and first-failure capture
    always_ff @(posedge clk) begin
        if (reset) begin
            vec        <= '0;
            cnt        <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (go) begin
            vec        <= '0;
            cnt        <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (state == APPLY) begin
            cnt <= (cnt == SET_END) ? '0 : cnt + 1'b1;
        end else if (state == SAMPLE) begin
            if (!stop)
                vec <= vec + 1'b1;
            if (mismatch) begin
                err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
                if (!fail_valid) begin
                    fail_vec   <= vec[N_IN-1:0];
                    fail_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tv_sequencer.sv
// tb_tv_sequencer: randomized self-checking bench for tv_sequencer across three parameter sets
module tb_tv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int sel = 0;
    int checks = 0;
    int failures = 0;
    logic [1:0] tt [3][16];
    logic [1:0] rom [3][16];

    always #5 clk = ~clk;

    logic [2:0] in_a, addr_a, fv_a, in_b, addr_b, fv_b;
    logic [3:0] in_c, addr_c, fv_c;
    logic out_a, exp_a, out_b, exp_b;
    logic [1:0] out_c, exp_c, err_b;
    logic [15:0] err_a, err_c;
    logic busy_a, done_a, pass_a, fvv_a, busy_b, done_b, pass_b, fvv_b, busy_c, done_c, pass_c, fvv_c;

    assign out_a = tt[0][in_a][0];
    assign out_b = tt[1][in_b][0];
    assign out_c = tt[2][in_c];
    always @(posedge clk) begin
        exp_a <= rom[0][addr_a][0];
        exp_b <= rom[1][addr_b][0];
        exp_c <= rom[2][addr_c];
    end

    tv_sequencer #(.N_IN(3), .N_OUT(1), .SETTLE(1), .ERR_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start && sel == 0), .dut_in(in_a), .dut_out(out_a),
        .exp_addr(addr_a), .exp_data(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .fail_vec(fv_a), .fail_valid(fvv_a));
    tv_sequencer #(.N_IN(3), .N_OUT(1), .SETTLE(1), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start && sel == 1), .dut_in(in_b), .dut_out(out_b),
        .exp_addr(addr_b), .exp_data(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .fail_vec(fv_b), .fail_valid(fvv_b));
    tv_sequencer #(.N_IN(4), .N_OUT(2), .SETTLE(3), .ERR_W(16)) dut_c (
        .clk(clk), .reset(reset), .start(start && sel == 2), .dut_in(in_c), .dut_out(out_c),
        .exp_addr(addr_c), .exp_data(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_cnt(err_c), .fail_vec(fv_c), .fail_valid(fvv_c));

    logic [3:0] o_in, o_addr, o_fv;
    logic [15:0] o_err;
    logic o_busy, o_done, o_pass, o_fvv;
    assign o_in   = sel == 0 ? {1'b0, in_a}   : sel == 1 ? {1'b0, in_b}   : in_c;
    assign o_addr = sel == 0 ? {1'b0, addr_a} : sel == 1 ? {1'b0, addr_b} : addr_c;
    assign o_fv   = sel == 0 ? {1'b0, fv_a}   : sel == 1 ? {1'b0, fv_b}   : fv_c;
    assign o_err  = sel == 0 ? err_a : sel == 1 ? {14'd0, err_b} : err_c;
    assign o_busy = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
    assign o_done = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
    assign o_pass = sel == 0 ? pass_a : sel == 1 ? pass_b : pass_c;
    assign o_fvv  = sel == 0 ? fvv_a  : sel == 1 ? fvv_b  : fvv_c;

    function automatic logic spec_fn(input int v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return (~b & ~c) | (a & ~b);
    endfunction

    task automatic set_golden(input int s);
        for (int v = 0; v < 8; v++) begin
            tt[s][v] = {1'b0, spec_fn(v)};
            rom[s][v] = tt[s][v];
        end
    endtask

    // Runs one full sequence on instance s and compares against the model built from tt/rom
    task automatic run(input int s, input string nm, input bit mid_start);
        int n, st, sat, errs, first, applied, exp_err, len, cycles;
        bit trace_ok;
        logic [1:0] mask;
        n = s == 2 ? 16 : 8;
        st = s == 2 ? 3 : 1;
        sat = s == 1 ? 3 : 65535;
        mask = s == 2 ? 2'b11 : 2'b01;
        errs = 0;
        first = -1;
        for (int v = 0; v < n; v++)
            if (((tt[s][v] ^ rom[s][v]) & mask) != 0) begin
                if (first < 0) first = v;
                errs++;
            end
        applied = n;
`ifdef TVSEQ_STOP_ON_FAIL_EN
        if (first >= 0) begin
            applied = first + 1;
            errs = 1;
        end
`endif
        exp_err = errs > sat ? sat : errs;
        len = applied * (st + 1);
        sel = s;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (o_err !== 16'd0 || o_fvv !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL %s cleared_at_start err=%0d fvv=%0b done=%0b required 0/0/0", nm, o_err, o_fvv, o_done);
        end
        cycles = 0;
        trace_ok = 1'b1;
        while (!o_done && cycles < 300) begin
            if (o_in !== 4'(cycles / (st + 1)) || o_addr !== o_in || o_busy !== 1'b1) trace_ok = 1'b0;
            start = mid_start && cycles == 3;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (!trace_ok) begin
            failures++;
            $display("FAIL %s trace dut_in/exp_addr/busy sequence wrong, required vec=cycle/%0d busy=1", nm, st + 1);
        end
        checks++;
        if (cycles != len) begin
            failures++;
            $display("FAIL %s run_length got=%0d required=%0d", nm, cycles, len);
        end
        checks++;
        if (o_err !== 16'(exp_err)) begin
            failures++;
            $display("FAIL %s err_cnt got=%0d required=%0d", nm, o_err, exp_err);
        end
        checks++;
        if (o_pass !== (errs == 0) || o_done !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s pass/done/busy got=%0b/%0b/%0b required=%0b/1/0", nm, o_pass, o_done, o_busy, errs == 0);
        end
        checks++;
        if (o_fvv !== (first >= 0) || o_fv !== 4'(first < 0 ? 0 : first)) begin
            failures++;
            $display("FAIL %s fail_vec got=%0d valid=%0b required=%0d valid=%0b", nm, o_fv, o_fvv, first < 0 ? 0 : first, first >= 0);
        end
        checks++;
        if (o_in !== 4'(applied - 1)) begin
            failures++;
            $display("FAIL %s dut_in_hold got=%0d required=%0d", nm, o_in, applied - 1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_a, in_b, in_c, addr_a, addr_c, busy_a, busy_b, busy_c, done_a, done_b, done_c,
             pass_a, pass_b, pass_c, err_a, err_b, err_c, fv_a, fv_b, fv_c, fvv_a, fvv_b, fvv_c} !== '0) begin
            failures++;
            $display("FAIL reset_values some output nonzero in_a=%0d err_a=%0d busy_a=%0b done_c=%0b required all 0", in_a, err_a, busy_a, done_c);
        end
        reset = 1'b0;
    endtask

    task automatic test_golden;
        set_golden(0);
        run(0, "golden", 1'b0);
    endtask

    task automatic test_corrupt;
        set_golden(0);
        rom[0][5] = 2'b00;
        run(0, "corrupt5", 1'b0);
    endtask

    task automatic test_inverted;
        set_golden(0);
        for (int v = 0; v < 8; v++) rom[0][v] = {1'b0, ~tt[0][v][0]};
        run(0, "inverted", 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 8; v++) begin
                tt[0][v] = {1'b0, 1'($urandom)};
                rom[0][v] = tt[0][v] ^ {1'b0, $urandom_range(0, 3) == 0};
            end
            run(0, "random_a", 1'b0);
        end
    endtask

    task automatic test_busy_start;
        set_golden(0);
        run(0, "start_while_busy", 1'b1);
    endtask

    task automatic test_saturation;
        set_golden(1);
        for (int v = 0; v < 8; v++) rom[1][v] = {1'b0, ~tt[1][v][0]};
        run(1, "saturate", 1'b0);
        run(1, "saturate_rerun", 1'b0);
        set_golden(1);
        run(1, "restart_clean", 1'b0);
    endtask

    task automatic test_wide;
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 16; v++) begin
                tt[2][v] = 2'($urandom);
                rom[2][v] = k == 0 ? tt[2][v] : tt[2][v] ^ ($urandom_range(0, 4) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
            end
            run(2, "wide", 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        set_golden(0);
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (in_a !== 3'd4 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 50) begin
            failures++;
            $display("FAIL reset_mid timeout waiting for vector 4 got dut_in=%0d required=4", in_a);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_a !== 3'd0 || err_a !== 16'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got dut_in=%0d err=%0d busy=%0b done=%0b required 0/0/0/0", in_a, err_a, busy_a, done_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stays_idle got busy=%0b done=%0b required 0/0", busy_a, done_a);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++)
            for (int v = 0; v < 16; v++) begin
                tt[s][v] = 2'b00;
                rom[s][v] = 2'b00;
            end
        test_reset;
        test_golden;
        test_corrupt;
        test_inverted;
        test_random;
        test_busy_start;
        test_saturation;
        test_wide;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
